// File: rtl/alu_exec_unit.sv
// Two-stage handshaked ALU execution unit: stage 1 captures a tagged request, stage 2
// computes the result and flags into the output registers under valid/ready backpressure.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_illegal,
  output logic [15:0]      done_cnt
);

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_SHIFT = 2'b01;
  localparam logic [1:0] CLS_LOGIC = 2'b10;

  // Returns {carry, result}; carry is the top bit of the WIDTH+1-bit sum.
  function automatic logic [WIDTH:0] arith_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [2:0]       code);
    logic [WIDTH:0] ax;
    logic [WIDTH:0] bx;
    logic [WIDTH:0] bn;
    logic [WIDTH:0] one;
    logic [WIDTH:0] r;
    ax  = {1'b0, a};
    bx  = {1'b0, b};
    bn  = {1'b0, ~b};
    one = {{WIDTH{1'b0}}, 1'b1};
    r   = '0;
    case (code)
      3'd0:    r = ax + bx;
      3'd1:    r = ax + bx + one;
      3'd2:    r = ax + bn + one;
      3'd3:    r = ax + bn;
      3'd4:    r = ax + one;
      3'd5:    r = ax + {1'b0, {WIDTH{1'b1}}};
      3'd6:    r = ax;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       code);
    logic [WIDTH-1:0] r;
    case (code)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] a,
                                                input logic             right);
    return right ? (a >> SHAMT) : (a << SHAMT);
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [4:0]       sel_p1;
  logic [TAG_W-1:0] tag_p1;

  logic             adv_p2;
  logic             adv_p1;
  logic [WIDTH-1:0] res_f;
  logic             res_carry;
  logic             res_illegal;

  assign adv_p2   = !out_valid || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = rst_n && adv_p1;

  // ---- stage 1: request capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      a_p1   <= in_a;
      b_p1   <= in_b;
      sel_p1 <= in_sel;
      tag_p1 <= in_tag;
    end
  end

  // ---- stage 2: compute ----
  always_comb begin
    res_f       = '0;
    res_carry   = 1'b0;
    res_illegal = 1'b0;
    case (sel_p1[4:3])
      CLS_ARITH: {res_carry, res_f} = arith_op(a_p1, b_p1, {sel_p1[0], sel_p1[1], sel_p1[2]});
      CLS_LOGIC: res_f = logic_op(a_p1, b_p1, {sel_p1[0], sel_p1[1]});
      CLS_SHIFT: res_f = shift_op(a_p1, sel_p1[1]);
      default:   res_illegal = 1'b1;
    endcase
  end

  // ---- stage 2: output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_f       <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_carry   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_f       <= res_f;
        out_tag     <= tag_p1;
        out_zero    <= (res_f == '0);
        out_carry   <= res_carry;
        out_illegal <= res_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus randomized traffic checked against a
// queue-based reference model of the opcode table and the handshake rules.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_sel;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_carry;
  logic        out_illegal;
  logic [15:0] done_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [38:0] exp_q[$];
  int          done_model = 0;
  logic        hold_prev  = 1'b0;
  logic [31:0] hold_f;
  logic [3:0]  hold_tag;

  alu_exec_unit #(.WIDTH(32), .SHAMT(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_tag(out_tag),
    .out_zero(out_zero), .out_carry(out_carry), .out_illegal(out_illegal),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: {illegal, zero, carry, f} straight from the opcode table.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sel);
    logic [31:0]     f;
    logic            c;
    logic            ill;
    longint unsigned s;
    f = 0; c = 0; ill = 0; s = 0;
    case (sel[4:3])
      2'b00: begin
        case ({sel[0], sel[1], sel[2]})
          3'd0: begin s = 64'(a) + 64'(b);     f = s[31:0]; c = s[32]; end
          3'd1: begin s = 64'(a) + 64'(b) + 1; f = s[31:0]; c = s[32]; end
          3'd2: begin f = a - b;     c = (a >= b); end
          3'd3: begin f = a - b - 1; c = (a > b);  end
          3'd4: begin f = a + 1;     c = (a == 32'hFFFF_FFFF); end
          3'd5: begin f = a - 1;     c = (a != 0); end
          3'd6: begin f = a;         c = 0; end
          default: begin f = 0;      c = 0; end
        endcase
      end
      2'b10: begin
        case ({sel[0], sel[1]})
          2'd0: f = a & b;
          2'd1: f = a | b;
          2'd2: f = a ^ b;
          default: f = ~a;
        endcase
      end
      2'b01: f = sel[1] ? (a >> 2) : (a << 2);
      default: ill = 1;
    endcase
    return {ill, (f == 0), c, f};
  endfunction

  // One clock: drive after posedge, evaluate handshakes and scoreboard at negedge.
  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sel, input logic [3:0] tag, input logic ordy,
                      output logic acc);
    logic [38:0] e;
    @(posedge clk);
    #1;
    in_valid = iv; in_a = a; in_b = b; in_sel = sel; in_tag = tag; out_ready = ordy;
    @(negedge clk);
    acc = in_valid && in_ready;
    chk("done_cnt", done_cnt, done_model);
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_f", out_f, hold_f);
      chk("hold_tag", out_tag, hold_tag);
    end
    if (out_valid && out_ready) begin
      chk("resp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_tag", out_tag, e[38:35]);
        chk("resp_illegal", out_illegal, e[34]);
        chk("resp_zero", out_zero, e[33]);
        chk("resp_carry", out_carry, e[32]);
        chk("resp_f", out_f, e[31:0]);
      end
      done_model = (done_model + 1) & 16'hFFFF;
    end
    if (acc) exp_q.push_back({in_tag, model(in_a, in_b, in_sel)});
    hold_prev = out_valid && !out_ready;
    hold_f    = out_f;
    hold_tag  = out_tag;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 32'h0, 32'h0, 5'h0, 4'h0, ordy, acc);
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sel, input logic [3:0] tag,
                         input logic [31:0] ef, input logic ec, input logic ez,
                         input logic eill);
    logic acc;
    step(1'b1, a, b, sel, tag, 1'b1, acc);
    chk({name, "_acc"}, acc, 1);
    idle(1'b1);
    chk({name, "_early"}, out_valid, 0);
    idle(1'b1);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_f"}, out_f, ef);
    chk({name, "_carry"}, out_carry, ec);
    chk({name, "_zero"}, out_zero, ez);
    chk({name, "_illegal"}, out_illegal, eill);
    chk({name, "_tag"}, out_tag, tag);
  endtask

  initial begin
    logic        acc;
    int          idx;
    int          cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corners[6];
    logic [31:0] t5_a[4];
    logic [4:0]  t5_sel[4];

    corners[0] = 32'h0; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h1; corners[5] = 32'hC000_0003;

    rst_n = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_sel = 0; in_tag = 0; out_ready = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_f", out_f, 0);
    chk("rst_done_cnt", done_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    chk("post_rst_in_ready", in_ready, 1);

    run_one("t1_sub", 32'd5, 32'd3, 5'b00010, 4'h1, 32'd2, 1, 0, 0);
    run_one("t2_add_wrap", 32'hFFFF_FFFF, 32'd1, 5'b00000, 4'h2, 32'h0, 1, 1, 0);
    run_one("t2_a_minus1", 32'h0, 32'h0, 5'b00110, 4'h3, 32'hFFFF_FFFF, 0, 0, 0);
    run_one("t3_xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 5'b10001, 4'h4, 32'h0FF0_0FF0, 0, 0, 0);
    run_one("t3_shr", 32'h8000_0003, 32'h1234_5678, 5'b01010, 4'h5, 32'h2000_0000, 0, 0, 0);
    run_one("t3_shl", 32'h8000_0003, 32'h0, 5'b01000, 4'h6, 32'h0000_000C, 0, 0, 0);
    run_one("t4_illegal", 32'hDEAD_BEEF, 32'h1234_5678, 5'b11000, 4'h9, 32'h0, 0, 1, 1);

    // Reset with two ops in flight.
    step(1'b1, 32'd10, 32'd20, 5'b00000, 4'hA, 1'b0, acc);
    step(1'b1, 32'd30, 32'd40, 5'b00000, 4'hB, 1'b0, acc);
    idle(1'b0);
    chk("t6_full_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_done", done_cnt, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_f", out_f, 0);
    exp_q.delete();
    done_model = 0;
    hold_prev  = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("t6_no_stale", out_valid, 0);
    end

    // Backpressure: 4 tagged ops, consumer stalled for 5 cycles.
    for (int i = 0; i < 4; i++) begin
      t5_a[i]   = 32'h100 * (i + 1);
      t5_sel[i] = 5'b00001 << (i % 2);
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, t5_a[idx], 32'h7, t5_sel[idx], 4'(idx + 1), 1'b0, acc);
      if (acc) idx++;
    end
    chk("t5_accepts", idx, 2);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_stall_tag", out_tag, 1);
    cyc = 0;
    while (!(idx == 4 && exp_q.size() == 0) && cyc < 20) begin
      step(idx < 4, t5_a[idx < 4 ? idx : 0], 32'h7, t5_sel[idx < 4 ? idx : 0],
           4'(idx + 1), 1'b1, acc);
      if (acc) idx++;
      cyc++;
    end
    chk("t5_drained", exp_q.size(), 0);
    idle(1'b1);
    chk("t5_done_cnt", done_cnt, 4);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      step($urandom_range(0, 9) < 7, ra, rb, 5'($urandom_range(0, 31)),
           4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7, acc);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      idle(1'b1);
      cyc++;
    end
    chk("rand_drained", exp_q.size(), 0);
    idle(1'b1);
    chk("rand_idle_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
